// File: rtl/alu_pkg.sv
// Shared ALUSel encoding, FSM state encoding and helpers for the execute-stage ALU.
// Used by alu_exec_unit and the ALU control decoder.
package alu_pkg;

    localparam int ALU_SEL_W = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB    = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL    = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT    = 4'b0011;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU   = 4'b0100;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR    = 4'b0101;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL    = 4'b0110;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA    = 4'b0111;
    localparam logic [ALU_SEL_W-1:0] ALU_OR     = 4'b1000;
    localparam logic [ALU_SEL_W-1:0] ALU_AND    = 4'b1001;
    localparam logic [ALU_SEL_W-1:0] ALU_PASS_B = 4'b1010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift_sel(input logic [ALU_SEL_W-1:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_datapath.sv
// Single-cycle ALU operations and undefined-code detection, purely combinational.
// Shift codes return op_a unshifted; the caller seeds its shifter from it.
module alu_comb_datapath
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_SEL_W-1:0] alu_sel,
    input  logic [XLEN-1:0]      op_a,
    input  logic [XLEN-1:0]      op_b,
    output logic [XLEN-1:0]      result,
    output logic                 illegal
);

    logic signed [XLEN-1:0] op_a_s;
    logic signed [XLEN-1:0] op_b_s;

    assign op_a_s = op_a;
    assign op_b_s = op_b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_sel)
            ALU_ADD:    result = op_a + op_b;
            ALU_SUB:    result = op_a - op_b;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:    result = op_a ^ op_b;
            ALU_OR:     result = op_a | op_b;
            ALU_AND:    result = op_a & op_b;
            ALU_PASS_B: result = op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:    result = op_a;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; shifts iterate one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter by a single-cycle barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_SEL_W-1:0] alu_sel,
    input  logic [XLEN-1:0]      op_a,
    input  logic [XLEN-1:0]      op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic                 zero,
    output logic                 illegal
);

    localparam int SHW = $clog2(XLEN);

    logic [1:0]      state;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] dp_result;
    logic            dp_illegal;

    assign shamt = op_b[SHW-1:0];

    alu_comb_datapath #(.XLEN(XLEN)) u_dp (
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (dp_result),
        .illegal (dp_illegal)
    );

`ifdef ALU_FAST_SHIFT_EN
    logic signed [XLEN-1:0] op_a_s;
    logic        [XLEN-1:0] accept_result;

    assign op_a_s = op_a;

    always_comb begin
        accept_result = dp_result;
        case (alu_sel)
            ALU_SLL: accept_result = op_a << shamt;
            ALU_SRL: accept_result = op_a >> shamt;
            ALU_SRA: accept_result = $unsigned(op_a_s >>> shamt);
            default: accept_result = dp_result;
        endcase
    end
`else
    logic [SHW-1:0]       cnt;
    logic [ALU_SEL_W-1:0] sel_q;

    function automatic logic [XLEN-1:0] shift_one(input logic [ALU_SEL_W-1:0] sel,
                                                  input logic [XLEN-1:0]      v);
        case (sel)
            ALU_SLL: return {v[XLEN-2:0], 1'b0};
            ALU_SRL: return {1'b0, v[XLEN-1:1]};
            default: return {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
                        result_q  <= accept_result;
                        illegal_q <= dp_illegal;
                        state     <= ST_DONE;
`else
                        // Zero-count shifts complete like any single-cycle op.
                        if (is_shift_sel(alu_sel) && (shamt != '0)) begin
                            result_q  <= op_a;
                            cnt       <= shamt;
                            sel_q     <= alu_sel;
                            illegal_q <= 1'b0;
                            state     <= ST_SHIFT;
                        end else begin
                            result_q  <= dp_result;
                            illegal_q <= dp_illegal;
                            state     <= ST_DONE;
                        end
`endif
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                ST_SHIFT: begin
                    result_q <= shift_one(sel_q, result_q);
                    cnt      <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALUSel code produced by the ALU control decoder, plus two XLEN-bit operands. Valid/ready on input and output. Non-shift ops complete in one cycle; shifts use an iterative 1-bit-per-cycle shifter. Sits between decode/operand fetch and writeback, in the same core as the ALU control decoder.

Parameters:
XLEN, 32, operand/result width
SHW, $clog2(XLEN), shift-amount width (derived; must not be overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  unit can accept an operation
alu_sel  input  4  ALUSel code from the ALU control decoder
op_a  input  XLEN  operand A (rs1)
op_b  input  XLEN  operand B (rs2/imm); shift amount = op_b[SHW-1:0]
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
result  output  XLEN  registered result
zero  output  1  (result == 0), combinational from the result register
illegal  output  1  registered; the op used an undefined alu_sel code

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on ports clk and rst.
- alu_sel codes:
  - 0000 ADD; 0001 SUB; 0010 SLL; 0011 SLT (signed); 0100 SLTU.
  - 0101 XOR; 0110 SRL; 0111 SRA; 1000 OR; 1001 AND.
  - 1010 PASS_B (result = op_b).
  - 1011-1111 undefined: result 0, illegal 1, latency 1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - SRA fills with op_a[XLEN-1].
  - Shift amounts use only the low SHW bits of op_b.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: in_valid & in_ready at edge T latches alu_sel, op_a and shift count.
  - Non-shift op, or shift with count 0: result is written at T; DONE from cycle T+1.
  - Shift with count n > 0: accumulator = op_a, state = SHIFT.
- SHIFT: each cycle shifts the accumulator one bit and decrements the count.
  - Leaving SHIFT on the cycle count == 1 goes to DONE.
  - out_valid asserts at cycle T+1+n.
- DONE:
  - result, zero and illegal are held stable while out_ready is low.
  - out_valid & out_ready returns the FSM to IDLE; in_ready rises the next cycle.
  - No accept in the same cycle as the output handshake; peak throughput is 1 op / 2 cycles.
- Inputs are ignored outside IDLE. Changes to op_a/op_b after accept have no effect.
- Reset values: state IDLE, result 0 (so zero = 1), illegal 0, out_valid 0, in_ready 1.
- Reset mid-operation (SHIFT or DONE) abandons the op. No stale out_valid after reset.

Optional Feature:
ALU_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter. Every op has latency 1, and the SHIFT state is never entered.
- Undefined: iterative shifter as described above, latency 1+n.
- Results are bit-identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - the ALUSel localparams (ALU_ADD ... ALU_PASS_B), shared with the ALU control decoder;
  - the FSM state encoding;
  - the ALU_SEL_W = 4 constant.
- One sub-module, alu_comb_datapath: purely combinational single-cycle ops (add/sub/compare/logic/pass) plus the illegal-code detect.
- The FSM, count and shift accumulator stay in alu_exec_unit.

Test Plan:
1. ADD, a=0xFFFFFFFF, b=1, out_ready=1: out_valid at T+1 with result=0 and zero=1. SUB, a=0, b=1: result=0xFFFFFFFF.
2. SRA, a=0x80000000, b=4: out_valid at T+5 with result=0xF8000000. With ALU_FAST_SHIFT_EN: out_valid at T+1 with the same result.
3. SLL, b=0x20 (count 0): out_valid at T+1, result=a. SLT, a=-1, b=1: result 1. SLTU with the same operands: result 0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid. result stays stable and in_ready stays 0; a new in_valid during this window is not accepted. Release out_ready: IDLE and in_ready=1 next cycle.
5. alu_sel=4'b1100: out_valid at T+1, result=0, illegal=1. The next legal op clears illegal.
6. Assert rst for one cycle during SHIFT (SRL, b=20, at cycle T+3): next cycle state IDLE, out_valid 0, result 0, in_ready 1.
